// File: rtl/encoder_16x4_seq.sv
// Sequential 16-to-4 encoder: accepts a multi-hot request word and streams out
// the binary index of each set bit, one beat per output handshake.
module encoder_16x4_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out,
    output logic        out_last,
    output logic [4:0]  cnt,
    output logic        zero_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pending;
    logic [15:0] w_pending_next;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_next;
    logic        r_zero_err;
    logic        w_zero_err_next;

    logic [3:0]  w_idx;
    logic [15:0] w_sel_mask;
    logic        w_last;
    logic [4:0]  w_popcount;

    // Index selection works only on the registered pending word, so out_ready
    // never reaches out or out_valid combinationally.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            always_comb begin
                w_idx = 4'd0;
                for (int i = 15; i >= 0; i--) begin
                    if (r_pending[i]) begin
                        w_idx = 4'(i);
                    end
                end
            end
        end else begin : g_msb_first
            always_comb begin
                w_idx = 4'd0;
                for (int i = 0; i < 16; i++) begin
                    if (r_pending[i]) begin
                        w_idx = 4'(i);
                    end
                end
            end
        end
    endgenerate

    assign w_sel_mask = 16'd1 << w_idx;
    assign w_last     = (r_pending != 16'd0) &&
                        ((r_pending & (r_pending - 16'd1)) == 16'd0);

    always_comb begin
        w_popcount = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_popcount = w_popcount + {4'd0, in[i]};
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pending_next  = r_pending;
        w_cnt_next      = r_cnt;
        w_zero_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_pending_next = in;
                    w_cnt_next     = w_popcount;
                    if (in != 16'd0) begin
                        w_state_next = S_EMIT;
                    end else begin
                        w_zero_err_next = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_pending_next = r_pending & ~w_sel_mask;
                    if (w_last) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_pending_next = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pending  <= 16'd0;
            r_cnt      <= 5'd0;
            r_zero_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_cnt      <= w_cnt_next;
            r_zero_err <= w_zero_err_next;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_EMIT);
    assign out       = (r_pending == 16'd0) ? 4'd0 : w_idx;
    assign out_last  = w_last;
    assign cnt       = r_cnt;
    assign zero_err  = r_zero_err;

endmodule

// File: tb/tb_encoder_16x4_seq.sv
// Bench for encoder_16x4_seq: LSB-first and MSB-first instances share stimulus;
// a scoreboard per instance holds the expected {index, last} beats.
module tb_encoder_16x4_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_vec = 16'd0;

    logic        l_in_ready, l_out_valid, l_out_last, l_zero_err;
    logic [3:0]  l_out;
    logic [4:0]  l_cnt;
    logic        m_in_ready, m_out_valid, m_out_last, m_zero_err;
    logic [3:0]  m_out;
    logic [4:0]  m_cnt;

    int checks = 0;
    int errors = 0;
    logic [4:0] q_l[$];
    logic [4:0] q_m[$];
    logic [4:0] e_l, e_m;

    encoder_16x4_seq #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
        .in(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
        .out(l_out), .out_last(l_out_last), .cnt(l_cnt), .zero_err(l_zero_err)
    );

    encoder_16x4_seq #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in(in_vec), .out_valid(m_out_valid), .out_ready(out_ready),
        .out(m_out), .out_last(m_out_last), .cnt(m_cnt), .zero_err(m_zero_err)
    );

    always #5 clk = ~clk;

    // Beats are popped at the falling edge preceding the accepting rising edge.
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (l_out_valid) begin
                checks++;
                if (q_l.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_beat: unexpected beat out=%0d last=%0b", l_out, l_out_last);
                end else begin
                    e_l = q_l.pop_front();
                    if ({l_out, l_out_last} !== e_l) begin
                        errors++;
                        $display("FAIL lsb_beat: got out=%0d last=%0b want out=%0d last=%0b",
                                 l_out, l_out_last, e_l[4:1], e_l[0]);
                    end
                end
            end
            if (m_out_valid) begin
                checks++;
                if (q_m.size() == 0) begin
                    errors++;
                    $display("FAIL msb_beat: unexpected beat out=%0d last=%0b", m_out, m_out_last);
                end else begin
                    e_m = q_m.pop_front();
                    if ({m_out, m_out_last} !== e_m) begin
                        errors++;
                        $display("FAIL msb_beat: got out=%0d last=%0b want out=%0d last=%0b",
                                 m_out, m_out_last, e_m[4:1], e_m[0]);
                    end
                end
            end
        end
    end

    function automatic logic [4:0] popc(input logic [15:0] v);
        logic [4:0] n = 5'd0;
        for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [15:0] v);
        int k = int'(popc(v));
        int seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                seen++;
                q_l.push_back({4'(i), seen == k});
            end
        end
        seen = 0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                seen++;
                q_m.push_back({4'(i), seen == k});
            end
        end
    endtask

    // Presents v for exactly one accepting edge; returns 1 ns after that edge.
    task automatic send(input logic [15:0] v);
        int t = 0;
        while (!l_in_ready && t < 200) begin
            step();
            t++;
        end
        checks++;
        if (!l_in_ready) begin
            errors++;
            $display("FAIL send_wait: in_ready=%0b after %0d cycles, want 1", l_in_ready, t);
        end
        in_vec   = v;
        in_valid = 1'b1;
        push_expected(v);
        step();
        in_valid = 1'b0;
        $display("send vector %h", v);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((q_l.size() != 0 || q_m.size() != 0 || !l_in_ready) && t < 300) begin
            step();
            t++;
        end
        checks++;
        if (q_l.size() != 0 || q_m.size() != 0 || !l_in_ready) begin
            errors++;
            $display("FAIL %s_drain: pending lsb=%0d msb=%0d in_ready=%0b, want 0 0 1",
                     name, q_l.size(), q_m.size(), l_in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if ({l_in_ready, l_out_valid, l_out, l_out_last, l_cnt, l_zero_err} !== {1'b1, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b vld=%0b out=%0d last=%0b cnt=%0d zerr=%0b want 1 0 0 0 0 0",
                     l_in_ready, l_out_valid, l_out, l_out_last, l_cnt, l_zero_err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sparse();
        out_ready = 1'b1;
        send(16'h8421);
        checks++;
        if (l_out_valid !== 1'b1 || l_out !== 4'd0 || l_cnt !== 5'd4) begin
            errors++;
            $display("FAIL sparse_first: vld=%0b out=%0d cnt=%0d want 1 0 4", l_out_valid, l_out, l_cnt);
        end
        repeat (3) step();
        checks++;
        if (l_in_ready !== 1'b0 || l_out !== 4'd15 || l_out_last !== 1'b1) begin
            errors++;
            $display("FAIL sparse_last: rdy=%0b out=%0d last=%0b want 0 15 1", l_in_ready, l_out, l_out_last);
        end
        step();
        checks++;
        if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sparse_return: rdy=%0b vld=%0b want 1 0", l_in_ready, l_out_valid);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        send(16'hFFFF);
        checks++;
        if (l_cnt !== 5'd16 || m_cnt !== 5'd16 || l_out !== 4'd0 || m_out !== 4'd15) begin
            errors++;
            $display("FAIL full_first: cnt=%0d/%0d out=%0d/%0d want 16/16 0/15", l_cnt, m_cnt, l_out, m_out);
        end
        repeat (15) step();
        checks++;
        if (l_out !== 4'd15 || l_out_last !== 1'b1 || m_out !== 4'd0 || m_out_last !== 1'b1) begin
            errors++;
            $display("FAIL full_last: lsb out=%0d last=%0b msb out=%0d last=%0b want 15 1 0 1",
                     l_out, l_out_last, m_out, m_out_last);
        end
        step();
        checks++;
        if (l_in_ready !== 1'b1 || m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_return: rdy=%0b/%0b want 1/1", l_in_ready, m_in_ready);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'h0012);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (l_out_valid !== 1'b1 || l_out !== 4'd1 || l_out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%0b out=%0d last=%0b want 1 1 0", c, l_out_valid, l_out, l_out_last);
            end
            if (c == 1) begin
                in_vec   = 16'hFFFF;
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        checks++;
        if (l_out !== 4'd1 || l_out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold3: out=%0d last=%0b want 1 0", l_out, l_out_last);
        end
        step();
        checks++;
        if (l_out !== 4'd4 || l_out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: out=%0d last=%0b want 4 1", l_out, l_out_last);
        end
        step();
        checks++;
        if (l_in_ready !== 1'b1 || l_cnt !== 5'd2 || l_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: rdy=%0b cnt=%0d vld=%0b want 1 2 0", l_in_ready, l_cnt, l_out_valid);
        end
    endtask

    task automatic test_zero();
        in_vec   = 16'h0000;
        in_valid = 1'b1;
        step();
        checks++;
        if (l_zero_err !== 1'b1 || l_in_ready !== 1'b1 || l_out_valid !== 1'b0 || l_cnt !== 5'd0) begin
            errors++;
            $display("FAIL zero_first: zerr=%0b rdy=%0b vld=%0b cnt=%0d want 1 1 0 0",
                     l_zero_err, l_in_ready, l_out_valid, l_cnt);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (l_zero_err !== 1'b1 || l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_b2b: zerr=%0b rdy=%0b vld=%0b want 1 1 0", l_zero_err, l_in_ready, l_out_valid);
        end
        step();
        checks++;
        if (l_zero_err !== 1'b0 || m_zero_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear: zerr=%0b/%0b want 0/0", l_zero_err, m_zero_err);
        end
        $display("zero vectors sent back to back");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(16'hF000);
        checks++;
        if (l_out !== 4'd12 || m_out !== 4'd15) begin
            errors++;
            $display("FAIL rmid_first: out=%0d/%0d want 12/15", l_out, m_out);
        end
        step();
        checks++;
        if (l_out !== 4'd13 || l_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_second: out=%0d vld=%0b want 13 1", l_out, l_out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({l_in_ready, l_out_valid, l_out, l_out_last, l_cnt, l_zero_err, m_out_valid} !==
            {1'b1, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_async: rdy=%0b vld=%0b out=%0d last=%0b cnt=%0d zerr=%0b mvld=%0b want 1 0 0 0 0 0 0",
                     l_in_ready, l_out_valid, l_out, l_out_last, l_cnt, l_zero_err, m_out_valid);
        end
        q_l.delete();
        q_m.delete();
        step();
        step();
        rst = 1'b0;
        step();
        send(16'h0001);
        checks++;
        if (l_out !== 4'd0 || l_out_last !== 1'b1 || m_out !== 4'd0 || m_out_last !== 1'b1) begin
            errors++;
            $display("FAIL rmid_single: out=%0d/%0d last=%0b/%0b want 0/0 1/1", l_out, m_out, l_out_last, m_out_last);
        end
        drain("rmid");
    endtask

    task automatic test_back_to_back();
        logic [15:0] vecs[8] = '{16'hA5A5, 16'h0001, 16'h8000, 16'h0000,
                                 16'h7FFE, 16'h0180, 16'hFFFF, 16'h1248};
        for (int n = 0; n < 8; n++) begin
            send(vecs[n]);
            checks++;
            if (l_cnt !== popc(vecs[n]) || m_cnt !== popc(vecs[n])) begin
                errors++;
                $display("FAIL b2b_cnt%0d: cnt=%0d/%0d want %0d", n, l_cnt, m_cnt, popc(vecs[n]));
            end
            for (int t = 0; t < 200 && !(l_in_ready && q_l.size() == 0 && q_m.size() == 0); t++) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            out_ready = 1'b1;
        end
        drain("b2b");
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_full();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
